intt_stage_sequencer: RTL and testbench

Control sequencer that drives the inverse-NTT butterfly unit across all log2(N) Gentleman-Sande stages of an in-place INTT over a single-port-pair coefficient RAM. Each cycle it issues one coefficient-pair read and one twiddle-ROM index, then delays the same addresses through a fixed pipeline to generate the write-back. It sits directly upstream of the butterfly and owns the RAM and ROM address buses. Final n⁻¹ scaling is out of scope.

---
 rtl/intt_pkg.sv | 18 +
 rtl/intt_wb_delay.sv | 44 ++++
 rtl/intt_stage_sequencer.sv | 149 ++++++++++++++
 tb/tb_intt_stage_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/intt_pkg.sv
// Shared types and defaults for the inverse-NTT stage sequencer.
package intt_pkg;

    localparam int INTT_N      = 256;
    localparam int INTT_LOGN   = 8;
    localparam int INTT_ADDR_W = 8;
    localparam int INTT_LAT    = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_WAIT,
        ST_DONE
    } intt_seq_state_t;

    typedef logic [INTT_ADDR_W-1:0] coef_addr_t;

endpackage

// File: rtl/intt_wb_delay.sv
// LAT-deep register pipeline turning a read strobe/address pair into
// the matching write-back strobe/address pair.
module intt_wb_delay #(
    parameter int W   = 8,
    parameter int LAT = 2
) (
    input  logic         clk_i,
    input  logic         reset_ni,
    input  logic         rd_en,
    input  logic [W-1:0] rd_addr1,
    input  logic [W-1:0] rd_addr2,
    output logic         wr_en,
    output logic [W-1:0] wr_addr1,
    output logic [W-1:0] wr_addr2
);

    logic         en_q [LAT];
    logic [W-1:0] a1_q [LAT];
    logic [W-1:0] a2_q [LAT];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < LAT; i++) begin
                en_q[i] <= 1'b0;
                a1_q[i] <= '0;
                a2_q[i] <= '0;
            end
        end else begin
            en_q[0] <= rd_en;
            a1_q[0] <= rd_addr1;
            a2_q[0] <= rd_addr2;
            for (int i = 1; i < LAT; i++) begin
                en_q[i] <= en_q[i-1];
                a1_q[i] <= a1_q[i-1];
                a2_q[i] <= a2_q[i-1];
            end
        end
    end

    assign wr_en    = en_q[LAT-1];
    assign wr_addr1 = a1_q[LAT-1];
    assign wr_addr2 = a2_q[LAT-1];

endmodule

// File: rtl/intt_stage_sequencer.sv
// Gentleman-Sande INTT address sequencer: one butterfly read per cycle,
// stage-by-stage, with write-back addresses delayed by the datapath latency.
module intt_stage_sequencer
    import intt_pkg::*;
#(
    parameter int N      = INTT_N,
    parameter int LOGN   = INTT_LOGN,
    parameter int ADDR_W = INTT_ADDR_W,
    parameter int LAT    = INTT_LAT
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     rd_en_o,
    output logic [ADDR_W-1:0]        rd_addr1_o,
    output logic [ADDR_W-1:0]        rd_addr2_o,
    output logic [ADDR_W-1:0]        w_idx_o,
    output logic                     wr_en_o,
    output logic [ADDR_W-1:0]        wr_addr1_o,
    output logic [ADDR_W-1:0]        wr_addr2_o,
    output logic [$clog2(LOGN)-1:0]  stage_o
);

    localparam int STG_W = $clog2(LOGN);
    localparam int WC_W  = (LAT > 1) ? $clog2(LAT) : 1;

    typedef logic [ADDR_W-1:0] addr_t;

    intt_seq_state_t state, state_nxt;

    logic [STG_W-1:0] stage;
    logic [WC_W-1:0]  wcnt;
    addr_t            grp;
    addr_t            off;
    addr_t            cnt;
    addr_t            k;
    addr_t            len;

    logic first;
    logic grp_end;
    logic stg_end;
    logic wait_end;
    logic last_stage;
    logic run;

    assign len        = addr_t'(1) << stage;
    assign first      = (off == '0);
    assign grp_end    = (off == len - addr_t'(1));
    assign stg_end    = (cnt == addr_t'(N/2 - 1));
    assign wait_end   = (wcnt == WC_W'(LAT - 1));
    assign last_stage = (stage == STG_W'(LOGN - 1));
    assign run        = (state == ST_RUN);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start_i) state_nxt = ST_RUN;
            ST_RUN:  if (stg_end) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (wait_end) state_nxt = last_stage ? ST_DONE : ST_RUN;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // k starts at N (wraps to 0 when N == 2**ADDR_W) and is pre-decremented
    // on the first pair of every group, so the unsigned wrap yields N-1.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            stage <= '0;
            wcnt  <= '0;
            grp   <= '0;
            off   <= '0;
            cnt   <= '0;
            k     <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        stage <= '0;
                        wcnt  <= '0;
                        grp   <= '0;
                        off   <= '0;
                        cnt   <= '0;
                        k     <= addr_t'(N);
                    end
                end
                ST_RUN: begin
                    cnt  <= cnt + addr_t'(1);
                    wcnt <= '0;
                    if (first) k <= k - addr_t'(1);
                    if (grp_end) begin
                        off <= '0;
                        grp <= grp + (len << 1);
                    end else begin
                        off <= off + addr_t'(1);
                    end
                end
                ST_WAIT: begin
                    wcnt <= wcnt + WC_W'(1);
                    if (wait_end && !last_stage) begin
                        stage <= stage + STG_W'(1);
                        grp   <= '0;
                        off   <= '0;
                        cnt   <= '0;
                    end
                end
                ST_DONE: begin
                    stage <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy_o     = (state != ST_IDLE);
    assign done_o     = (state == ST_DONE);
    assign rd_en_o    = run;
    assign rd_addr1_o = run ? grp + off : '0;
    assign rd_addr2_o = run ? grp + off + len : '0;
    assign w_idx_o    = run ? (first ? k - addr_t'(1) : k) : '0;
    assign stage_o    = stage;

    intt_wb_delay #(
        .W   (ADDR_W),
        .LAT (LAT)
    ) u_wb_delay (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .rd_en    (rd_en_o),
        .rd_addr1 (rd_addr1_o),
        .rd_addr2 (rd_addr2_o),
        .wr_en    (wr_en_o),
        .wr_addr1 (wr_addr1_o),
        .wr_addr2 (wr_addr2_o)
    );

endmodule

// File: tb/tb_intt_stage_sequencer.sv
// Randomised self-checking bench for intt_stage_sequencer against a
// cycle-index model of the INTT loop nest.
module tb_intt_stage_sequencer;

    localparam int N    = 256;
    localparam int LOGN = 8;
    localparam int AW   = 8;
    localparam int LAT  = 2;
    localparam int SPAN = N/2 + LAT;
    localparam int LAST = LOGN * SPAN;
    localparam int DONE_T = LAST + 1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy, done, rd_en, wr_en;
    logic [AW-1:0] rd_a1, rd_a2, w_idx, wr_a1, wr_a2;
    logic [2:0]    stage;

    int total = 0;
    int bad   = 0;
    int t     = 0;

    intt_stage_sequencer dut (
        .clk_i      (clk),
        .reset_ni   (rst_n),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .rd_en_o    (rd_en),
        .rd_addr1_o (rd_a1),
        .rd_addr2_o (rd_a2),
        .w_idx_o    (w_idx),
        .wr_en_o    (wr_en),
        .wr_addr1_o (wr_a1),
        .wr_addr2_o (wr_a2),
        .stage_o    (stage)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%0d want=%0d", name, t, act, exp);
        end
    endtask

    // Read issued in run-cycle tt, from the loop nest directly.
    function automatic void rd_model(input int tt, output logic en,
                                     output int a1, output int a2,
                                     output int w);
        int s, p, len, g, o;
        en = 1'b0; a1 = 0; a2 = 0; w = 0;
        if (tt >= 1 && tt <= LAST) begin
            s = (tt - 1) / SPAN;
            p = (tt - 1) % SPAN;
            if (p < N/2) begin
                len = 1 << s;
                g   = p / len;
                o   = p % len;
                a1  = g * 2 * len + o;
                a2  = a1 + len;
                w   = (N >> s) - 1 - g;
                en  = 1'b1;
            end
        end
    endfunction

    // t = cycles since the accepting start edge; 0 means idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) t = 0;
        else if (t == 0) t = start ? 1 : 0;
        else if (t >= DONE_T) t = 0;
        else t = t + 1;
    end

    always @(negedge clk) begin
        logic e_rd, e_wr;
        int r1, r2, rw, q1, q2, qw, es;
        rd_model(t, e_rd, r1, r2, rw);
        rd_model(t - LAT, e_wr, q1, q2, qw);
        es = (t >= 1 && t <= LAST) ? (t - 1) / SPAN :
             (t == DONE_T) ? LOGN - 1 : 0;
        check("busy", 32'(busy), 32'(t != 0));
        check("done", 32'(done), 32'(t == DONE_T));
        check("rd_en", 32'(rd_en), 32'(e_rd));
        check("rd_addr1", 32'(rd_a1), r1);
        check("rd_addr2", 32'(rd_a2), r2);
        check("w_idx", 32'(w_idx), rw);
        check("wr_en", 32'(wr_en), 32'(e_wr));
        check("wr_addr1", 32'(wr_a1), q1);
        check("wr_addr2", 32'(wr_a2), q2);
        check("stage", 32'(stage), es);
        if (t == 1) begin
            check("lit_c1", {rd_a1, rd_a2, w_idx}, {8'd0, 8'd1, 8'd255});
        end
        if (t == 2) begin
            check("lit_c2", {rd_a1, rd_a2, w_idx}, {8'd2, 8'd3, 8'd254});
        end
        if (t == 3) begin
            check("lit_c3_wr", {wr_en, wr_a1, wr_a2}, {1'b1, 8'd0, 8'd1});
        end
        if (t == 129 || t == 130) check("lit_gap", 32'(rd_en), 0);
        if (t == 131) begin
            check("lit_c131", {rd_a1, rd_a2, w_idx}, {8'd0, 8'd2, 8'd127});
        end
        if (t == 132) begin
            check("lit_c132", {rd_a1, rd_a2, w_idx}, {8'd1, 8'd3, 8'd127});
        end
        if (t == 133) begin
            check("lit_c133", {rd_a1, rd_a2, w_idx}, {8'd4, 8'd6, 8'd126});
        end
        if (t == 1038) begin
            check("lit_last_rd", {rd_en, rd_a1, rd_a2, w_idx},
                  {1'b1, 8'd127, 8'd255, 8'd1});
        end
        if (t == 1040) begin
            check("lit_last_wr", {wr_en, wr_a1, wr_a2},
                  {1'b1, 8'd127, 8'd255});
        end
        if (t == 1041) check("lit_done", 32'(done), 1);
    end

    task automatic wait_t(input int target);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (t == target) break;
        end
        if (t != target) begin
            bad++;
            $display("FAIL wait_t reached=%0d want=%0d", t, target);
        end
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic zero_check();
        check("rst_out", {busy, done, rd_en, rd_a1, rd_a2, w_idx,
                          wr_en, wr_a1, wr_a2, stage}, 0);
    endtask

    // Random start pulses while busy must have no effect.
    task automatic noisy_run(input int stop_at);
        int nxt;
        nxt = 1 + $urandom_range(0, 60);
        while (nxt < stop_at && nxt < DONE_T) begin
            wait_t(nxt);
            pulse_start();
            nxt = t + 1 + $urandom_range(1, 200);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        #1 zero_check();
        repeat (cycles) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int rt;
        rst_n = 1'b0;
        start = 1'b0;
        #1 zero_check();
        repeat (3) @(posedge clk);
        #1 zero_check();
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #2;

        pulse_start();
        wait_t(500);
        pulse_start();
        wait_t(DONE_T);
        @(posedge clk); #2;
        pulse_start();

        wait_t(299);
        @(posedge clk); #2;
        do_reset(3);
        repeat ($urandom_range(2, 12)) @(posedge clk);
        #2;

        pulse_start();
        noisy_run(DONE_T);
        wait_t(DONE_T);
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #2;

        pulse_start();
        rt = $urandom_range(1, DONE_T);
        noisy_run(rt);
        wait_t(rt);
        #1;
        do_reset($urandom_range(1, 4));
        repeat (2) @(posedge clk);
        #2;

        pulse_start();
        wait_t(DONE_T);
        repeat (4) @(posedge clk);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
